dsp_i2s_dac_tx: RTL and testbench

I2S master transmitter that feeds processed audio back to the WM8731 codec DAC. It is the output end of the audio path: the ADC receiver and the DSP chain produce signed 16-bit stereo samples, and this block serializes them into I2S format. It generates BCLK and DACLRCK from the system clock and emits a one-cycle frame tick, which downstream holders and meters use as their sample clock. A one-entry holding buffer with a valid/ready handshake decouples the DSP chain from the serial frame timing.

---
 rtl/dsp_pkg.sv | 7 +
 rtl/dsp_i2s_clkgen.sv | 38 +++
 rtl/dsp_i2s_dac_tx.sv | 88 ++++++++
 tb/tb_dsp_i2s_dac_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared audio-path types and I2S timing constants (used by the DAC transmitter and the ADC receiver)
package dsp_pkg;
  typedef logic signed [15:0] audio_t;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_BCLK_HALF = 3;
  localparam int I2S_WS = 16;
endpackage

// File: rtl/dsp_i2s_clkgen.sv
// dsp_i2s_clkgen: I2S bit-clock divider and frame bit counter
// Ports: iCLK/iRST system clock and async reset; oBCLK bit clock;
//        oFall strobe for the cycle in which oBCLK has just fallen and oBit advanced;
//        oBit frame bit index 0..2*SLOT_BITS-1.
module dsp_i2s_clkgen #(
  parameter int BCLK_HALF = 3,
  parameter int SLOT_BITS = 32
) (
  input  logic iCLK,
  input  logic iRST,
  output logic oBCLK,
  output logic oFall,
  output logic [$clog2(2*SLOT_BITS)-1:0] oBit
);
  localparam int CW = $clog2(BCLK_HALF + 1);
  logic [CW-1:0] cnt;
  logic tc;
  assign tc = cnt == CW'(BCLK_HALF - 1);
  // oBit resets to all ones so the first falling edge wraps it to 0 (frame start);
  // SLOT_BITS is a power of two, so the natural binary wrap is the frame wrap.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt <= '0;
      oBCLK <= 1'b0;
      oFall <= 1'b0;
      oBit <= '1;
    end else begin
      oFall <= tc && oBCLK;
      if (tc) begin
        cnt <= '0;
        oBCLK <= !oBCLK;
        if (oBCLK) oBit <= oBit + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dsp_i2s_dac_tx.sv
// dsp_i2s_dac_tx: I2S master transmitter with one-entry holding buffer feeding the codec DAC
// Ports: iCLK/iRST clock and async reset; iLeft/iRight/iValid/oReady sample-pair handshake;
//        oBCLK/oDACLRCK/oDACDAT I2S lines; oFrame frame-start pulse; oUnderrun empty-buffer frame pulse.
module dsp_i2s_dac_tx
  import dsp_pkg::*;
#(
  parameter int BCLK_HALF = I2S_BCLK_HALF,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int WS = I2S_WS
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic signed [WS-1:0] iLeft,
  input  logic signed [WS-1:0] iRight,
  input  logic iValid,
  output logic oReady,
  output logic oBCLK,
  output logic oDACLRCK,
  output logic oDACDAT,
  output logic oFrame,
  output logic oUnderrun
);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [BW-2:0] WSP = (BW-1)'(WS);
  logic fall, right, slotBit, full;
  logic [BW-1:0] b;
  logic [BW-2:0] p;
  logic [WS-1:0] bufL, bufR, lastL, lastR, txL, txR;
  dsp_i2s_clkgen #(.BCLK_HALF(BCLK_HALF), .SLOT_BITS(SLOT_BITS)) uClk (
    .iCLK(iCLK),
    .iRST(iRST),
    .oBCLK(oBCLK),
    .oFall(fall),
    .oBit(b)
  );
  // Top bit of the frame index selects the channel; the low bits are the slot position.
  assign p = b[BW-2:0];
  assign right = b[BW-1];
  // Slot position 0 stays low, giving the one-BCLK delay after the LRCK edge.
  assign slotBit = (p != '0) && (p <= WSP);
  assign oReady = !full;
  // Accept needs an empty buffer and the frame-start load needs a full one, so the two never collide.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      full <= 1'b0;
      bufL <= '0;
      bufR <= '0;
      lastL <= '0;
      lastR <= '0;
      txL <= '0;
      txR <= '0;
      oDACLRCK <= 1'b0;
      oDACDAT <= 1'b0;
      oFrame <= 1'b0;
      oUnderrun <= 1'b0;
    end else begin
      oFrame <= 1'b0;
      oUnderrun <= 1'b0;
      if (iValid && !full) begin
        full <= 1'b1;
        bufL <= iLeft;
        bufR <= iRight;
      end
      if (fall) begin
        oDACLRCK <= right;
        oDACDAT <= 1'b0;
        if (b == '0) begin
          oFrame <= 1'b1;
          if (full) begin
            txL <= bufL;
            txR <= bufR;
            lastL <= bufL;
            lastR <= bufR;
            full <= 1'b0;
          end else begin
            txL <= lastL;
            txR <= lastR;
            oUnderrun <= 1'b1;
          end
        end else if (slotBit) begin
          oDACDAT <= right ? txR[WS-1] : txL[WS-1];
          if (right) txR <= {txR[WS-2:0], 1'b0};
          else txL <= {txL[WS-2:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_dsp_i2s_dac_tx.sv
// tb_dsp_i2s_dac_tx: scoreboard bench for the I2S DAC transmitter
module tb_dsp_i2s_dac_tx;
  import dsp_pkg::*;
  typedef struct {
    int tag;
    logic [15:0] l;
    logic [15:0] r;
  } acc_t;
  logic iCLK = 1'b0, iRST = 1'b1, iValid = 1'b0;
  audio_t iLeft = '0, iRight = '0;
  logic oReady, oBCLK, oDACLRCK, oDACDAT, oFrame, oUnderrun;
  int checks = 0, errors = 0, cyc = 0, relCyc = 0, framesChecked = 0;
  acc_t accQ[$];
  logic [15:0] lastL = '0, lastR = '0, expL = '0, expR = '0;
  logic datBits[64], lrBits[64];
  logic prevB = 1'b0, collecting = 1'b0;
  int pos = 0, lastFrame = -1;

  always #5 iCLK = ~iCLK;

  dsp_i2s_dac_tx dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iLeft(iLeft),
    .iRight(iRight),
    .iValid(iValid),
    .oReady(oReady),
    .oBCLK(oBCLK),
    .oDACLRCK(oDACLRCK),
    .oDACDAT(oDACDAT),
    .oFrame(oFrame),
    .oUnderrun(oUnderrun)
  );

  always @(posedge iCLK) cyc <= cyc + 1;
  always @(posedge iCLK or posedge iRST) relCyc <= iRST ? 0 : relCyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: accepted pairs are queued with the edge on which they were
  // taken; each frame start pops a pair taken strictly before it, otherwise repeats the last one.
  always @(negedge iCLK) begin
    if (iRST) begin
      accQ.delete();
      lastL = '0;
      lastR = '0;
      collecting = 1'b0;
      lastFrame = -1;
    end else begin
      if (oUnderrun && !oFrame) chk("underrun_without_frame", 1, 0);
      if (oFrame) begin
        logic u;
        if (accQ.size() > 0 && accQ[0].tag < cyc) begin
          acc_t e;
          e = accQ.pop_front();
          lastL = e.l;
          lastR = e.r;
          u = 1'b0;
        end else u = 1'b1;
        chk("underrun", oUnderrun, u);
        if (lastFrame >= 0) chk("frame_period", cyc - lastFrame, 384);
        lastFrame = cyc;
        expL = lastL;
        expR = lastR;
        collecting = 1'b1;
        pos = 0;
      end
      if (iValid && oReady) accQ.push_back('{cyc + 1, iLeft, iRight});
      if (collecting && oBCLK && !prevB) begin
        datBits[pos] = oDACDAT;
        lrBits[pos] = oDACLRCK;
        pos++;
        if (pos == 64) begin
          logic [15:0] l, r;
          logic lrOk, zOk;
          l = '0;
          r = '0;
          lrOk = 1'b1;
          zOk = 1'b1;
          for (int k = 0; k < 64; k++) begin
            int p;
            p = k % 32;
            if (lrBits[k] !== (k >= 32)) lrOk = 1'b0;
            if (p >= 1 && p <= 16) begin
              if (k < 32) l = {l[14:0], datBits[k]};
              else r = {r[14:0], datBits[k]};
            end else if (datBits[k] !== 1'b0) zOk = 1'b0;
          end
          chk("left_word", l, expL);
          chk("right_word", r, expR);
          chk("lrck_pattern", lrOk, 1);
          chk("idle_bits_zero", zOk, 1);
          collecting = 1'b0;
          framesChecked++;
        end
      end
    end
    prevB = oBCLK;
  end

  task automatic waitRel(input int n);
    while (relCyc < n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic checkResetVals(input string name);
    chk(name, {oBCLK, oDACLRCK, oDACDAT, oReady, oFrame, oUnderrun}, 6'b000100);
  endtask

  task automatic doReset();
    iRST = 1'b1;
    iValid = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    checkResetVals("reset_values");
  endtask

  task automatic checkRelease();
    int fb, ff;
    fb = 0;
    ff = 0;
    @(negedge iCLK) iRST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge iCLK);
      #1;
      if (oBCLK && fb == 0) fb = k;
      if (oFrame && ff == 0) ff = k;
    end
    chk("first_bclk_rise_cycle", fb, 3);
    chk("first_frame_cycle", ff, 7);
  endtask

  task automatic plainRelease();
    @(negedge iCLK) iRST = 1'b0;
    @(posedge iCLK);
    #1;
  endtask

  // Caller is always just after a rising edge; returns just after the accepting edge.
  task automatic sendPair(input logic [15:0] l, input logic [15:0] r, output int t);
    logic rd, done;
    int n;
    n = 0;
    done = 1'b0;
    iLeft = l;
    iRight = r;
    iValid = 1'b1;
    while (!done) begin
      @(negedge iCLK) rd = oReady;
      @(posedge iCLK);
      #1;
      if (rd) done = 1'b1;
      else if (++n > 1000) begin
        chk("accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
    t = relCyc;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    int accT[5];
    doReset();
    checkRelease();
    waitRel(800);
    doReset();
    plainRelease();
    sendPair(16'h8001, 16'h7FFE, t);
    iValid = 1'b0;
    waitRel(774);
    iLeft = 16'h1234;
    iRight = 16'hABCD;
    iValid = 1'b1;
    waitRel(775);
    iValid = 1'b0;
    chk("simul_accept_ready", oReady, 0);
    chk("simul_underrun", oUnderrun, 1);
    waitRel(1940);
    doReset();
    plainRelease();
    for (int i = 0; i < 5; i++) sendPair(16'h0100 + 16'(i), 16'hFF00 - 16'(i), accT[i]);
    iValid = 1'b0;
    for (int i = 2; i < 5; i++) chk("accept_spacing", accT[i] - accT[i-1], 384);
    waitRel(2330);
    doReset();
    plainRelease();
    sendPair(16'h5A5A, 16'hA5A5, t);
    iValid = 1'b0;
    waitRel(8);
    sendPair(16'h0F0F, 16'hF0F0, t);
    iValid = 1'b0;
    waitRel(207);
    chk("ready_before_midreset", oReady, 0);
    iRST = 1'b1;
    #1;
    checkResetVals("midframe_reset_values");
    repeat (3) @(posedge iCLK);
    checkRelease();
    waitRel(400);
    chk("frames_decoded", framesChecked >= 12, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
